// File: rtl/z80_pkg.sv
// Shared types and constants for the Z80 LD IX/IY,nn fetch sequencer.
package z80_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFPfx,
        StFOp,
        StFNl,
        StFNh,
        StWrite,
        StAbort
    } state_e;

    localparam logic [7:0] PfxDd   = 8'hDD;
    localparam logic [7:0] PfxFd   = 8'hFD;
    localparam logic [7:0] OpLdNn  = 8'h21;
    localparam logic [3:0] InsnLen = 4'd4;

    // Byte offset from the instruction base fetched in each fetch state.
    function automatic logic [1:0] fetch_offset(input state_e st);
        case (st)
            StFOp:   fetch_offset = 2'd1;
            StFNl:   fetch_offset = 2'd2;
            StFNh:   fetch_offset = 2'd3;
            default: fetch_offset = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/z80_ixiy_ld_seq.sv
// Fetches and executes LD IX,nn (DD 21 lo hi) / LD IY,nn (FD 21 lo hi).
// Optional trace port enabled by defining Z80FI_EN.
module z80_ixiy_ld_seq
    import z80_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ip_in,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        busy,
    output logic        reg_wr,
    output logic        reg_sel,
    output logic [15:0] reg_wdata,
    output logic [15:0] ip_out,
    output logic        done,
`ifdef Z80FI_EN
    output logic        illegal,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [3:0]  z80fi_insn_len
`else
    output logic        illegal
`endif
);

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  nl_q, nl_d;
    logic        reg_sel_q, reg_sel_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic [15:0] ip_out_q, ip_out_d;
`ifdef Z80FI_EN
    logic [31:0] insn_q, insn_d;
    logic [3:0]  insn_len_q, insn_len_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            base_q      <= 16'h0;
            nl_q        <= 8'h0;
            reg_sel_q   <= 1'b0;
            reg_wdata_q <= 16'h0;
            ip_out_q    <= 16'h0;
`ifdef Z80FI_EN
            insn_q      <= 32'h0;
            insn_len_q  <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nl_q        <= nl_d;
            reg_sel_q   <= reg_sel_d;
            reg_wdata_q <= reg_wdata_d;
            ip_out_q    <= ip_out_d;
`ifdef Z80FI_EN
            insn_q      <= insn_d;
            insn_len_q  <= insn_len_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        nl_d        = nl_q;
        reg_sel_d   = reg_sel_q;
        reg_wdata_d = reg_wdata_q;
        ip_out_d    = ip_out_q;
`ifdef Z80FI_EN
        insn_d      = insn_q;
        insn_len_d  = insn_len_q;
`endif
        mem_rd      = 1'b0;
        mem_addr    = 16'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = ip_in;
                    state_d = StFPfx;
                end
            end
            StFPfx: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    if (mem_data == PfxDd || mem_data == PfxFd) begin
                        reg_sel_d = mem_data[5];
                        state_d   = StFOp;
                    end else begin
                        ip_out_d = base_q;
                        state_d  = StAbort;
                    end
                end
            end
            StFOp: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    if (mem_data == OpLdNn) begin
                        state_d = StFNl;
                    end else begin
                        ip_out_d = base_q;
                        state_d  = StAbort;
                    end
                end
            end
            StFNl: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    nl_d    = mem_data;
                    state_d = StFNh;
                end
            end
            StFNh: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    // Result registers load here so they are valid throughout WRITE.
                    reg_wdata_d = {mem_data, nl_q};
                    ip_out_d    = base_q + 16'd4;
`ifdef Z80FI_EN
                    insn_d      = {mem_data, nl_q, OpLdNn, reg_sel_q ? PfxFd : PfxDd};
                    insn_len_d  = InsnLen;
`endif
                    state_d     = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (mem_rd) begin
            mem_addr = base_q + {14'd0, fetch_offset(state_q)};
        end
    end

    assign busy      = (state_q != StIdle);
    assign reg_wr    = (state_q == StWrite);
    assign done      = (state_q == StWrite);
    assign illegal   = (state_q == StAbort);
    assign reg_sel   = reg_sel_q;
    assign reg_wdata = reg_wdata_q;
    assign ip_out    = ip_out_q;

`ifdef Z80FI_EN
    assign z80fi_valid    = (state_q == StWrite);
    assign z80fi_insn     = insn_q;
    assign z80fi_insn_len = insn_len_q;
`endif

endmodule

// File: tb/tb_z80_ixiy_ld_seq.sv
// Scoreboard bench for z80_ixiy_ld_seq: stimulus queues expected retirements,
// a negedge monitor compares them; a memory model checks fetch addresses.
module tb_z80_ixiy_ld_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] ip_in;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        busy, reg_wr, reg_sel, done, illegal;
    logic [15:0] reg_wdata, ip_out;
`ifdef Z80FI_EN
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [3:0]  z80fi_insn_len;
`endif

    z80_ixiy_ld_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ip_in     (ip_in),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .busy      (busy),
        .reg_wr    (reg_wr),
        .reg_sel   (reg_sel),
        .reg_wdata (reg_wdata),
        .ip_out    (ip_out),
        .done      (done),
`ifdef Z80FI_EN
        .illegal        (illegal),
        .z80fi_valid    (z80fi_valid),
        .z80fi_insn     (z80fi_insn),
        .z80fi_insn_len (z80fi_insn_len)
`else
        .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        bit          sel;
        logic [15:0] nn;
        logic [15:0] ip;
        int          exp_cyc;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] addr_q[$];
    logic [7:0]  mem [0:65535];
    int          wait_n = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, {mem_rd, mem_addr, busy, reg_wr, reg_sel, reg_wdata, ip_out, done, illegal},
            64'h0);
`ifdef Z80FI_EN
        chk({name, "_fi"}, {z80fi_valid, z80fi_insn, z80fi_insn_len}, 64'h0);
`endif
    endtask

    // Memory model: wait_n idle cycles then ack; address must hold while waiting.
    initial begin
        int          cnt;
        logic [15:0] held;
        logic [15:0] ea;
        cnt = 0;
        held = 16'h0;
        mem_ack = 1'b0;
        mem_data = 8'h0;
        forever begin
            @(negedge clk);
            if (!mem_rd) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt > 0) chk("addr_stable", mem_addr, held);
                else held = mem_addr;
                if (cnt >= wait_n) begin
                    mem_ack = 1'b1;
                    mem_data = mem[mem_addr];
                    cnt = 0;
                    if (addr_q.size() == 0) begin
                        chk("unexpected_fetch", mem_addr, 16'hxxxx);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("fetch_addr", mem_addr, ea);
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Retirement monitor.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (reg_wr || illegal)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", {reg_wr, illegal}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_ill_done", {reg_wr, illegal, done}, e.ill ? 3'b010 : 3'b101);
                    chk("ip_out", ip_out, e.ip);
                    if (!e.ill) begin
                        chk("reg_sel", reg_sel, e.sel);
                        chk("reg_wdata", reg_wdata, e.nn);
                    end
                    if (e.exp_cyc != 0) chk("retire_cycle", 64'(cyc), 64'(e.exp_cyc));
`ifdef Z80FI_EN
                    chk("fi_valid", z80fi_valid, done);
                    if (!e.ill) begin
                        chk("fi_insn", z80fi_insn, {e.nn, 8'h21, e.sel ? 8'hFD : 8'hDD});
                        chk("fi_len", z80fi_insn_len, 4'd4);
                    end
`endif
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, busy, 1'b0);
    endtask

    // lat: cycle after the start-sampling edge in which the retire pulse appears (0 = don't check).
    task automatic run_seq(input string name, input logic [15:0] base, input int waits,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int nfetch, input bit ill,
                           input bit sel, input logic [15:0] nn, input logic [15:0] ip,
                           input int lat);
        sb_t e;
        mem[base] = b0;
        mem[base + 16'd1] = b1;
        mem[base + 16'd2] = b2;
        mem[base + 16'd3] = b3;
        wait_n = waits;
        for (int i = 0; i < nfetch; i++) addr_q.push_back(base + 16'(i));
        @(negedge clk);
        e.ill = ill;
        e.sel = sel;
        e.nn = nn;
        e.ip = ip;
        e.exp_cyc = (lat != 0) ? cyc + lat : 0;
        sb_q.push_back(e);
        ip_in = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (waits > 0) begin
            // A start mid-sequence must be ignored.
            repeat (2) @(negedge clk);
            ip_in = 16'h5555;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        bit  found;
        int  c;
        reset_n = 1'b1;
        start = 1'b0;
        ip_in = 16'h0;
        #3 reset_n = 1'b0;
        #1 check_zero("reset_state");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // LD IY,1234 at 0100, zero wait
        run_seq("ld_iy", 16'h0100, 0, 8'hFD, 8'h21, 8'h34, 8'h12, 4, 0, 1, 16'h1234, 16'h0104, 5);
        repeat (3) @(negedge clk);
        chk("hold_wdata", reg_wdata, 16'h1234);
        chk("hold_ip_out", ip_out, 16'h0104);
        chk("hold_sel", reg_sel, 1'b1);

        // LD IX,ABCD with 3 wait cycles per byte
        run_seq("ld_ix_wait", 16'h2000, 3, 8'hDD, 8'h21, 8'hCD, 8'hAB, 4, 0, 0, 16'hABCD,
                16'h2004, 0);
        // Bad prefix, bad opcode
        run_seq("bad_pfx", 16'h3000, 1, 8'hED, 8'h21, 8'h00, 8'h00, 1, 1, 0, 16'h0, 16'h3000, 0);
        run_seq("bad_op", 16'h3100, 0, 8'hDD, 8'h22, 8'h00, 8'h00, 2, 1, 0, 16'h0, 16'h3100, 3);
        repeat (2) @(negedge clk);
        chk("abort_keeps_wdata", reg_wdata, 16'hABCD);
        // Address wrap
        run_seq("wrap", 16'hFFFE, 0, 8'hDD, 8'h21, 8'h78, 8'h56, 4, 0, 0, 16'h5678, 16'h0002, 5);

        // Reset during F_NL
        mem[16'h4000] = 8'hFD;
        mem[16'h4001] = 8'h21;
        mem[16'h4002] = 8'hEF;
        mem[16'h4003] = 8'hBE;
        wait_n = 3;
        addr_q.push_back(16'h4000);
        addr_q.push_back(16'h4001);
        @(negedge clk);
        ip_in = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (mem_rd && mem_addr == 16'h4002) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_f_nl", found, 1'b1);
        reset_n = 1'b0;
        #1 check_zero("reset_mid_seq");
        repeat (3) @(negedge clk);
        check_zero("reset_held");
        reset_n = 1'b1;
        chk("reset_fetch_count", addr_q.size(), 0);
        run_seq("after_reset", 16'h4000, 0, 8'hFD, 8'h21, 8'hEF, 8'hBE, 4, 0, 1, 16'hBEEF,
                16'h4004, 5);

        // start held high: two back-to-back sequences
        mem[16'h5000] = 8'hFD;
        mem[16'h5001] = 8'h21;
        mem[16'h5002] = 8'h11;
        mem[16'h5003] = 8'h22;
        mem[16'h5004] = 8'hDD;
        mem[16'h5005] = 8'h21;
        mem[16'h5006] = 8'h33;
        mem[16'h5007] = 8'h44;
        wait_n = 0;
        for (int i = 0; i < 8; i++) addr_q.push_back(16'h5000 + 16'(i));
        @(negedge clk);
        c = cyc;
        e.ill = 0; e.sel = 1; e.nn = 16'h2211; e.ip = 16'h5004; e.exp_cyc = c + 5;
        sb_q.push_back(e);
        e.ill = 0; e.sel = 0; e.nn = 16'h4433; e.ip = 16'h5008; e.exp_cyc = c + 11;
        sb_q.push_back(e);
        ip_in = 16'h5000;
        start = 1'b1;
        @(negedge clk);
        ip_in = 16'h5004;
        for (int i = 0; i < 50; i++) begin
            if (cyc >= c + 11) break;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle("back_to_back");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("fetches_drained", addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
